// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field layout, rounding-mode codes,
// canned result patterns, operand classification and divider FSM encoding.
package fpu_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [2:0] RNE = 3'b000;
   localparam logic [2:0] RTZ = 3'b001;
   localparam logic [2:0] RDN = 3'b010;
   localparam logic [2:0] RUP = 3'b011;
   localparam logic [2:0] RMM = 3'b100;

   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam logic [30:0] MAXF = 31'h7F7FFFFF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV  = 2'd1;
   localparam logic [1:0] ST_RND  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      FC_ZERO = 2'd0,
      FC_INF  = 2'd1,
      FC_NAN  = 2'd2,
      FC_NORM = 2'd3
   } fp_class_e;

   // Exponent 0 counts as zero, so subnormals are flushed.
   function automatic fp_class_e fp_class(input logic [FP_W-1:0] f);
      if (f[FP_W-2:FRAC_W] == '0)
         return FC_ZERO;
      else if (f[FP_W-2:FRAC_W] == {EXP_W{1'b1}})
         return (f[FRAC_W-1:0] == '0) ? FC_INF : FC_NAN;
      else
         return FC_NORM;
   endfunction

endpackage

// File: rtl/fp_div_if.sv
// Request/result bundle between the ALU issue logic and the FP divider.
interface fp_div_if;
   logic        start;
   logic [31:0] fp_X;
   logic [31:0] fp_Y;
   logic [2:0]  r_mode;
   logic        busy;
   logic        done;
   logic [31:0] fp_Z;
   logic        ovrf;
   logic        udrf;

   modport master (output start, fp_X, fp_Y, r_mode,
                   input  busy, done, fp_Z, ovrf, udrf);
   modport slave  (input  start, fp_X, fp_Y, r_mode,
                   output busy, done, fp_Z, ovrf, udrf);
endinterface

// File: rtl/fp_div_round.sv
// Normalise, round and pack stage for a 27-bit quotient. Purely combinational
// so the rounding table can be shared with other FPU units.
module fp_div_round
   import fpu_pkg::*;
(
   input  logic [26:0]       q,
   input  logic              rem_nz,
   input  logic signed [9:0] e_in,
   input  logic              sign,
   input  logic [2:0]        r_mode,
   output logic [31:0]       fp_Z,
   output logic              ovrf,
   output logic              udrf
);
   logic [23:0]       sig;
   logic              guard, sticky, inc;
   logic [24:0]       sum;
   logic signed [9:0] e_n, e_r;
   logic [22:0]       frac;

   // Normalise on the quotient MSB, apply the rounding increment, then pack or saturate.
   always_comb begin
      if (q[26]) begin
         sig    = q[26:3];
         guard  = q[2];
         sticky = (|q[1:0]) | rem_nz;
         e_n    = e_in;
      end else begin
         sig    = q[25:2];
         guard  = q[1];
         sticky = q[0] | rem_nz;
         e_n    = e_in - 10'sd1;
      end

      case (r_mode)
         RNE:     inc = guard & (sticky | sig[0]);
         RTZ:     inc = 1'b0;
         RDN:     inc = (guard | sticky) & sign;
         RUP:     inc = (guard | sticky) & ~sign;
         RMM:     inc = guard;
         default: inc = guard & (sticky | sig[0]);
      endcase

      sum = {1'b0, sig} + {24'd0, inc};
      if (sum[24]) begin
         frac = sum[23:1];
         e_r  = e_n + 10'sd1;
      end else begin
         frac = sum[22:0];
         e_r  = e_n;
      end

      ovrf = 1'b0;
      udrf = 1'b0;
      fp_Z = {sign, e_r[7:0], frac};
      if (e_r >= 10'sd255) begin
         ovrf = 1'b1;
         case (r_mode)
            RTZ:     fp_Z = {sign, MAXF};
            RDN:     fp_Z = sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, MAXF};
            RUP:     fp_Z = sign ? {1'b1, MAXF} : {1'b0, 8'hFF, 23'd0};
            default: fp_Z = {sign, 8'hFF, 23'd0};
         endcase
      end else if (e_r <= 10'sd0) begin
         udrf = 1'b1;
         fp_Z = {sign, 31'd0};
      end
   end
endmodule

// File: rtl/fp_div.sv
// Sequential FP32 divider: radix-2 restoring quotient loop, one bit per cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | wait for start; special operands resolve here straight to DONE
//  DIV     | one quotient bit per cycle, counter 26 down to 0
//  RND     | quotient complete; register rounded result
//  DONE    | done pulse, result valid
module fp_div
   import fpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   fp_div_if.slave  bus
);
   logic [1:0]        state;
   logic [4:0]        cnt;
   logic [24:0]       rem;
   logic [23:0]       div;
   logic [26:0]       q;
   logic signed [9:0] e_q;
   logic              sign_q;
   logic [2:0]        mode_q;
   logic [31:0]       z_q;
   logic              ovrf_q, udrf_q;

   fp_class_e         cls_x, cls_y;
   logic              sign_in, is_nan, is_inf, is_zero, special;
   logic [31:0]       special_z;
   logic signed [9:0] e_in;
   logic              q_bit;
   logic [24:0]       rem_sub;
   logic [31:0]       rnd_z;
   logic              rnd_ovrf, rnd_udrf;

   assign sign_in = bus.fp_X[31] ^ bus.fp_Y[31];
   assign e_in    = {2'b00, bus.fp_X[30:23]} - {2'b00, bus.fp_Y[30:23]} + 10'(EXP_BIAS);
   assign q_bit   = rem >= {1'b0, div};
   assign rem_sub = q_bit ? (rem - {1'b0, div}) : rem;

   // Classify incoming operands; NaN takes priority, then inf, then zero.
   always_comb begin
      cls_x     = fp_class(bus.fp_X);
      cls_y     = fp_class(bus.fp_Y);
      is_nan    = (cls_x == FC_NAN) || (cls_y == FC_NAN) ||
                  (cls_x == FC_ZERO && cls_y == FC_ZERO) ||
                  (cls_x == FC_INF  && cls_y == FC_INF);
      is_inf    = (cls_x == FC_INF) || (cls_y == FC_ZERO);
      is_zero   = (cls_x == FC_ZERO) || (cls_y == FC_INF);
      special   = is_nan | is_inf | is_zero;
      special_z = {sign_in, 31'd0};
      if (is_nan)
         special_z = QNAN;
      else if (is_inf)
         special_z = {sign_in, 8'hFF, 23'd0};
   end

   fp_div_round u_round (
      .q      (q),
      .rem_nz (|rem),
      .e_in   (e_q),
      .sign   (sign_q),
      .r_mode (mode_q),
      .fp_Z   (rnd_z),
      .ovrf   (rnd_ovrf),
      .udrf   (rnd_udrf)
   );

   // FSM, operand capture, restoring-division datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         rem    <= '0;
         div    <= '0;
         q      <= '0;
         e_q    <= '0;
         sign_q <= 1'b0;
         mode_q <= '0;
         z_q    <= '0;
         ovrf_q <= 1'b0;
         udrf_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.start) begin
               sign_q <= sign_in;
               mode_q <= bus.r_mode;
               e_q    <= e_in;
               rem    <= {2'b01, bus.fp_X[22:0]};
               div    <= {1'b1, bus.fp_Y[22:0]};
               q      <= '0;
               cnt    <= 5'd26;
               if (special) begin
                  z_q    <= special_z;
                  ovrf_q <= 1'b0;
                  udrf_q <= 1'b0;
                  state  <= ST_DONE;
               end else begin
                  state  <= ST_DIV;
               end
            end
            ST_DIV: begin
               rem <= rem_sub << 1;
               q   <= {q[25:0], q_bit};
               if (cnt == 5'd0)
                  state <= ST_RND;
               else
                  cnt <= cnt - 5'd1;
            end
            ST_RND: begin
               z_q    <= rnd_z;
               ovrf_q <= rnd_ovrf;
               udrf_q <= rnd_udrf;
               state  <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.fp_Z = z_q;
   assign bus.ovrf = ovrf_q;
   assign bus.udrf = udrf_q;
endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases with fixed expected values,
// then random operands against an integer-division reference model.
module tb_fp_div;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fp_div_if bus();

   fp_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
             (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
   endfunction

   // Reference: {fp_Z, ovrf, udrf} from exact integer quotient and remainder.
   function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
      int ex, ey, e;
      bit xz, xi, xn, yz, yi, yn, s, g, st, inc;
      longint mx, my, num, qq, sig;
      logic [2:0] mm;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {32'h7FC00000, 2'b00};
      if (xi || yz) return {s, 8'hFF, 23'd0, 2'b00};
      if (xz || yi) return {s, 31'd0, 2'b00};
      mx = 64'h800000 | longint'(x[22:0]);
      my = 64'h800000 | longint'(y[22:0]);
      if (mx >= my) begin
         num = mx << 25;
         e   = ex - ey + 127;
      end else begin
         num = mx << 26;
         e   = ex - ey + 126;
      end
      qq  = num / my;
      sig = qq >> 2;
      g   = qq[1];
      st  = qq[0] || ((num % my) != 0);
      mm  = (m > 3'd4) ? 3'd0 : m;
      case (mm)
         3'd1:    inc = 1'b0;
         3'd2:    inc = (g || st) && s;
         3'd3:    inc = (g || st) && !s;
         3'd4:    inc = g;
         default: inc = g && (st || sig[0]);
      endcase
      sig = sig + longint'(inc);
      if (sig == 64'h1000000) begin
         sig = sig >> 1;
         e   = e + 1;
      end
      if (e >= 255) begin
         case (mm)
            3'd1:    return {s, 31'h7F7FFFFF, 2'b10};
            3'd2:    return s ? {32'hFF800000, 2'b10} : {32'h7F7FFFFF, 2'b10};
            3'd3:    return s ? {32'hFF7FFFFF, 2'b10} : {32'h7F800000, 2'b10};
            default: return {s, 8'hFF, 23'd0, 2'b10};
         endcase
      end
      if (e <= 0) return {s, 31'd0, 2'b01};
      return {s, 8'(e), sig[22:0], 2'b00};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0]  ex;
      logic [22:0] fr;
      int r;
      r  = int'($urandom_range(0, 9));
      fr = 23'($urandom);
      if (r == 0) begin
         ex = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
         if ($urandom_range(0, 1) == 1) fr = '0;
      end else if (r < 3) begin
         ex = 8'($urandom_range(1, 254));
      end else begin
         ex = 8'($urandom_range(100, 154));
      end
      return {1'($urandom_range(0, 1)), ex, fr};
   endfunction

   task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] m, input logic [33:0] exp_v, input int lat_exp);
      int n;
      bus.fp_X   = x;
      bus.fp_Y   = y;
      bus.r_mode = m;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat_exp));
      check({tag, " result"}, {30'd0, bus.fp_Z, bus.ovrf, bus.udrf}, {30'd0, exp_v});
      @(posedge clk); #1;
      check({tag, " pulse"}, {63'd0, bus.done}, 64'd0);
   endtask

   initial begin
      int n, nd;
      logic [31:0] x, y;
      logic [2:0]  m;
      bus.start  = 1'b0;
      bus.fp_X   = '0;
      bus.fp_Y   = '0;
      bus.r_mode = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outs", {29'd0, bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("6/2 rne",     32'h40C00000, 32'h40000000, 3'd0, {32'h40400000, 2'b00}, 29);
      do_op("1/3 rne",     32'h3F800000, 32'h40400000, 3'd0, {32'h3EAAAAAB, 2'b00}, 29);
      do_op("1/3 rtz",     32'h3F800000, 32'h40400000, 3'd1, {32'h3EAAAAAA, 2'b00}, 29);
      do_op("1/3 rup",     32'h3F800000, 32'h40400000, 3'd3, {32'h3EAAAAAB, 2'b00}, 29);
      do_op("1/3 rdn",     32'h3F800000, 32'h40400000, 3'd2, {32'h3EAAAAAA, 2'b00}, 29);
      do_op("-1/3 rdn",    32'hBF800000, 32'h40400000, 3'd2, {32'hBEAAAAAB, 2'b00}, 29);
      do_op("1/3 mode7",   32'h3F800000, 32'h40400000, 3'd7, {32'h3EAAAAAB, 2'b00}, 29);
      do_op("x/0",         32'h3F800000, 32'h00000000, 3'd0, {32'h7F800000, 2'b00}, 1);
      do_op("0/0",         32'h00000000, 32'h00000000, 3'd0, {32'h7FC00000, 2'b00}, 1);
      do_op("sub/1",       32'h00000001, 32'h3F800000, 3'd0, {32'h00000000, 2'b00}, 1);
      do_op("-inf/2",      32'hFF800000, 32'h40000000, 3'd0, {32'hFF800000, 2'b00}, 1);
      do_op("ovf rne",     32'h7F000000, 32'h3E800000, 3'd0, {32'h7F800000, 2'b10}, 29);
      do_op("ovf rtz",     32'h7F000000, 32'h3E800000, 3'd1, {32'h7F7FFFFF, 2'b10}, 29);
      do_op("udf",         32'h00800000, 32'h40000000, 3'd0, {32'h00000000, 2'b01}, 29);

      // Start pulsed mid-DIV with different operands must be ignored.
      bus.fp_X = 32'h40C00000; bus.fp_Y = 32'h40000000; bus.r_mode = 3'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      repeat (4) begin @(posedge clk); #1; n++; end
      bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'd1; bus.start = 1'b1;
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      while (!bus.done && n < 60) begin @(posedge clk); #1; n++; end
      check("busy start latency", 64'(n), 64'd29);
      check("busy start result", {30'd0, bus.fp_Z, bus.ovrf, bus.udrf}, {30'd0, 32'h40400000, 2'b00});
      @(posedge clk); #1;

      // Reset in the tenth DIV cycle drops the operation.
      bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("busy before rst", {63'd0, bus.busy}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid rst outs", {29'd0, bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf}, 64'd0);
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done) nd++;
      end
      check("no done after rst", 64'(nd), 64'd0);
      do_op("after rst", 32'h40C00000, 32'h40000000, 3'd0, {32'h40400000, 2'b00}, 29);

      for (int i = 0; i < 60; i++) begin
         x = rnd_op();
         y = rnd_op();
         m = 3'($urandom_range(0, 7));
         do_op($sformatf("rand%0d %h/%h m%0d", i, x, y, m), x, y, m,
               ref_div(x, y, m), is_special(x, y) ? 1 : 29);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
